seq_divider: RTL and testbench

- Sequential restoring divider. It is the inverse companion of the combinational `multiplier` and shares the adder/two's-complement arithmetic family.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Controlled by a start/busy/done handshake; sits beside the adder and multiplier in the datapath for the DIV/MOD operations.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_div_step.sv | 25 ++
 rtl/seq_divider.sv | 145 ++++++++++++++
 tb/tb_seq_divider.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider: state encoding,
// default operand width and the divide-by-zero quotient fill.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Every quotient bit is set when the divisor is zero.
    localparam logic DIV0_QUOT_BIT = 1'b1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and attempt to subtract the divisor.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {rem, dvd_msb};
    assign trial   = shifted - {1'b0, divisor};

    // rem < divisor on entry, so the top bit of the WIDTH+1 trial is a true borrow.
    assign q_bit    = ~trial[WIDTH];
    assign next_rem = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Build option: define SIGNED_DIV_EN to honour signed_op (two's-complement operands).
//
// state | meaning
// IDLE  | waiting for start; results and div_by_zero hold
// RUN   | one shift-subtract step per edge, WIDTH steps in total
// DONE  | done pulse, results valid, busy still high
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic [WIDTH-1:0] next_rem;
    logic             q_bit;
    logic [WIDTH-1:0] quo_raw;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef SIGNED_DIV_EN
    logic neg_quo_q;
    logic neg_rem_q;
    logic sgn_dvd;
    logic sgn_dsr;

    assign sgn_dvd = signed_op & dividend[WIDTH-1];
    assign sgn_dsr = signed_op & divisor[WIDTH-1];
    assign dvd_mag = sgn_dvd ? -dividend : dividend;
    assign dsr_mag = sgn_dsr ? -divisor  : divisor;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign dvd_mag          = dividend;
    assign dsr_mag          = divisor;
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[WIDTH-1]),
        .divisor  (dsr_q),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    assign quo_raw = {dvd_q[WIDTH-2:0], q_bit};

`ifdef SIGNED_DIV_EN
    // Sign correction is folded into result registration so latency is unchanged.
    assign quo_fix = neg_quo_q ? -quo_raw  : quo_raw;
    assign rem_fix = neg_rem_q ? -next_rem : next_rem;
`else
    assign quo_fix = quo_raw;
    assign rem_fix = next_rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            done        <= 1'b1;
                            quotient    <= {WIDTH{DIV0_QUOT_BIT}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            rem_q   <= '0;
                            dvd_q   <= dvd_mag;
                            dsr_q   <= dsr_mag;
                            cnt_q   <= '0;
`ifdef SIGNED_DIV_EN
                            neg_quo_q <= sgn_dvd ^ sgn_dsr;
                            neg_rem_q <= sgn_dvd;
`endif
                        end
                    end
                end
                RUN: begin
                    rem_q <= next_rem;
                    dvd_q <= quo_raw;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quotient  <= quo_fix;
                        remainder <= rem_fix;
                        done      <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed cases plus random operands
// checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_seq_divider;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             signed_op = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               acc;
        int               lat;
    } exp_t;

    exp_t sb[$];
    logic [WIDTH-1:0] hold_q = '0;
    logic [WIDTH-1:0] hold_r = '0;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .signed_op   (signed_op),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain division; signed mode uses integer division (truncates toward zero).
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s);
        exp_t e;
        e.acc = 0;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.lat = 0;
        end else begin
            e.q = a / b;
            e.r = a % b;
`ifdef SIGNED_DIV_EN
            if (s) begin
                int da;
                int db;
                da  = $signed(a);
                db  = $signed(b);
                e.q = WIDTH'(da / db);
                e.r = WIDTH'(da % db);
            end
`else
            if (s) e.dz = 1'b0;
`endif
            e.dz  = 1'b0;
            e.lat = WIDTH;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        exp_t e;
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: busy=%0b still set after %0d cycles", busy, n);
            return;
        end
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        signed_op = s;
        e         = model(a, b, s);
        e.acc     = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0 || busy) begin
            bad++;
            $display("FAIL drain: got pending=%0d busy=%0b expected pending=0 busy=0",
                     sb.size(), busy);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
                continue;
            end
            if (prev_done) begin
                check("done_single_pulse", {31'd0, done}, 32'd0);
                check("busy_low_after_done", {31'd0, busy}, 32'd0);
            end
            if (busy && !done) begin
                check("quotient_hold", {24'd0, quotient}, {24'd0, hold_q});
                check("remainder_hold", {24'd0, remainder}, {24'd0, hold_r});
            end
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 q=%0h r=%0h expected no done",
                             quotient, remainder);
                end else begin
                    e = sb.pop_front();
                    check("quotient", {24'd0, quotient}, {24'd0, e.q});
                    check("remainder", {24'd0, remainder}, {24'd0, e.r});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    check("latency", cyc - e.acc, e.lat);
                    check("busy_with_done", {31'd0, busy}, 32'd1);
                    hold_q = e.q;
                    hold_r = e.r;
                end
            end
            prev_done = done;
        end
    end

    initial begin : stim
        int n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic s;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd10, 8'd7, 1'b0);
        drain();

        issue(8'd200, 8'd13, 1'b0);
        issue(8'd255, 8'd1, 1'b0);
        drain();

        issue(8'd37, 8'd0, 1'b0);
        issue(8'd6, 8'd3, 1'b0);
        drain();

        // start during RUN and during DONE must both be ignored
        issue(8'd100, 8'd9, 1'b0);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done_seen_100_9", {31'd0, done}, 32'd1);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd2;
        @(negedge clk);
        start = 1'b0;
        drain();

        // asynchronous reset in the middle of RUN
        issue(8'd50, 8'd4, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_done", {31'd0, done}, 32'd0);
        check("midrun_rst_quotient", {24'd0, quotient}, 32'd0);
        check("midrun_rst_remainder", {24'd0, remainder}, 32'd0);
        check("midrun_rst_dz", {31'd0, div_by_zero}, 32'd0);
        sb.delete();
        hold_q = '0;
        hold_r = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_resume_after_rst", {31'd0, busy}, 32'd0);
        issue(8'd50, 8'd4, 1'b0);
        drain();

        issue(8'hF6, 8'd3, 1'b1);
        issue(8'h80, 8'hFF, 1'b1);
        issue(8'h80, 8'd0, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            a = WIDTH'($urandom);
            b = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
            if ($urandom_range(0, 4) == 0) b = WIDTH'($urandom_range(1, 3));
            s = 1'($urandom_range(0, 1));
            issue(a, b, s);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
